// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, byte phase and default bit timing.
package uart_pkg;

    // Default bit period: 50 MHz system clock at 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic {
        PHASE_LOW  = 1'b0,
        PHASE_HIGH = 1'b1
    } byte_phase_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: RX synchroniser, bit timer, framing FSM and shift register.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       frame_err,
    output logic       active
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    logic          sync_meta;
    logic          rx_sync;
    rx_state_t     state;
    rx_state_t     state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;

    // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b1;
            rx_sync   <= 1'b1;
        end else begin
            sync_meta <= rx;
            rx_sync   <= sync_meta;
        end
    end

    // FSM, bit timer, bit index and shift register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    // Next-state logic: half-bit start check, then full-bit sampling of data and stop bits.
    always_comb begin
        state_next   = state;
        timer_next   = timer + TW'(1);
        bit_idx_next = bit_idx;
        shift_next   = shift;
        byte_done    = 1'b0;
        frame_err    = 1'b0;
        case (state)
            S_IDLE: begin
                timer_next = '0;
                if (!rx_sync) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (timer == HALF_LAST) begin
                    timer_next = '0;
                    if (rx_sync) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next   = S_DATA;
                        bit_idx_next = '0;
                    end
                end
            end
            S_DATA: begin
                if (timer == BIT_LAST) begin
                    timer_next          = '0;
                    shift_next[bit_idx] = rx_sync;
                    bit_idx_next        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (timer == BIT_LAST) begin
                    timer_next = '0;
                    state_next = S_IDLE;
                    byte_done  = rx_sync;
                    frame_err  = !rx_sync;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign rx_byte = shift;
    assign active  = (state != S_IDLE);

endmodule

// File: rtl/uart_word_rx.sv
// Host-link receiver: pairs received UART bytes (low byte first) into 16-bit Hack words.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RX,
    output logic [15:0] DATA,
    output logic        VALID,
    output logic        ERROR,
    output logic        BUSY
);

    logic        [7:0] rx_byte;
    logic              byte_done;
    logic              frame_err;
    logic              frame_active;
    byte_phase_t       phase;
    logic        [7:0] low_byte;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk      (CLK),
        .rst      (RST),
        .rx       (RX),
        .rx_byte  (rx_byte),
        .byte_done(byte_done),
        .frame_err(frame_err),
        .active   (frame_active)
    );

    // Word assembly: hold the low byte, emit the word on the high byte; a framing error drops the pair.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase    <= PHASE_LOW;
            low_byte <= '0;
            DATA     <= '0;
            VALID    <= 1'b0;
            ERROR    <= 1'b0;
        end else begin
            VALID <= 1'b0;
            ERROR <= 1'b0;
            if (frame_err) begin
                ERROR <= 1'b1;
                phase <= PHASE_LOW;
            end else if (byte_done) begin
                if (phase == PHASE_LOW) begin
                    low_byte <= rx_byte;
                    phase    <= PHASE_HIGH;
                end else begin
                    DATA  <= {rx_byte, low_byte};
                    VALID <= 1'b1;
                    phase <= PHASE_LOW;
                end
            end
        end
    end

    assign BUSY = frame_active || (phase == PHASE_HIGH);

endmodule

// File: tb/tb_uart_word_rx.sv
// Scoreboard bench for uart_word_rx: a byte-level model predicts words/errors, a monitor checks them.
module tb_uart_word_rx;

    localparam int CPB = 8;

    typedef struct {
        bit          is_err;
        logic [15:0] word;
        int          stop_cyc;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic        RX;
    logic [15:0] DATA;
    logic        VALID;
    logic        ERROR;
    logic        BUSY;

    int          checks;
    int          failures;
    int          cyc;
    exp_t        exp_q[$];
    bit          pend;
    logic [7:0]  pend_lo;
    logic [15:0] prev_data;
    logic        prev_rst;

    uart_word_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .RX   (RX),
        .DATA (DATA),
        .VALID(VALID),
        .ERROR(ERROR),
        .BUSY (BUSY)
    );

    // Free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Cycle counter used for pulse latency measurement.
    always @(posedge CLK) begin
        cyc++;
    end

    // Safety net so a stuck run still terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic driveBit(input logic v);
        RX = v;
        repeat (CPB) @(negedge CLK);
    endtask

    // Sends one 8N1 frame and updates the pairing model at the stop bit.
    task automatic applyStimulus(input logic [7:0] b, input bit stop_ok);
        exp_t e;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            driveBit(b[i]);
        end
        e.stop_cyc = cyc;
        e.is_err   = !stop_ok;
        e.word     = 16'h0000;
        if (!stop_ok) begin
            exp_q.push_back(e);
            pend = 1'b0;
        end else if (pend) begin
            e.word = {b, pend_lo};
            exp_q.push_back(e);
            pend = 1'b0;
        end else begin
            pend    = 1'b1;
            pend_lo = b;
        end
        driveBit(stop_ok);
        RX = 1'b1;
    endtask

    task automatic idleBits(input int n);
        RX = 1'b1;
        repeat (n * CPB) @(negedge CLK);
    endtask

    // Monitor: pops the scoreboard on every VALID/ERROR pulse and checks DATA holds otherwise.
    always @(negedge CLK) begin
        exp_t e;
        int   lat;
        if (!RST) begin
            if (!prev_rst && !VALID) begin
                checkOutput("data_hold", {16'h0, DATA}, {16'h0, prev_data});
            end
            if (VALID || ERROR) begin
                checkOutput("valid_error_exclusive", {31'h0, VALID & ERROR}, 32'h0);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_pulse: actual VALID=%0b ERROR=%0b DATA=%h required=no pulse", VALID, ERROR, DATA);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_is_error", {31'h0, ERROR}, {31'h0, e.is_err});
                    if (!e.is_err) begin
                        checkOutput("word", {16'h0, DATA}, {16'h0, e.word});
                    end
                    lat = cyc - e.stop_cyc;
                    checks++;
                    if (lat < 6 || lat > 8) begin
                        failures++;
                        $display("[TB] FAIL latency: actual=%0d required=6..8", lat);
                    end
                end
            end
        end
        prev_data = DATA;
        prev_rst  = RST;
    end

    initial begin
        bit saw_busy;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        pend     = 1'b0;
        pend_lo  = 8'h00;
        prev_rst = 1'b1;
        RST      = 1'b1;
        RX       = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        checkOutput("reset_data", {16'h0, DATA}, 32'h0);
        checkOutput("reset_valid", {31'h0, VALID}, 32'h0);
        checkOutput("reset_error", {31'h0, ERROR}, 32'h0);
        checkOutput("reset_busy", {31'h0, BUSY}, 32'h0);
        idleBits(2);

        $display("[TB] word receive 0x1234");
        applyStimulus(8'h34, 1'b1);
        checkOutput("busy_low_pending", {31'h0, BUSY}, 32'h1);
        applyStimulus(8'h12, 1'b1);
        idleBits(2);

        $display("[TB] back-to-back words");
        applyStimulus(8'hEF, 1'b1);
        applyStimulus(8'hBE, 1'b1);
        applyStimulus(8'hAD, 1'b1);
        applyStimulus(8'hDE, 1'b1);
        idleBits(2);

        $display("[TB] framing error");
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'hAA, 1'b0);
        idleBits(1);
        checkOutput("busy_after_error", {31'h0, BUSY}, 32'h0);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b1);
        idleBits(2);

        $display("[TB] start glitch");
        RX = 1'b0;
        repeat (2) @(negedge CLK);
        RX = 1'b1;
        saw_busy = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (BUSY) saw_busy = 1'b1;
        end
        checkOutput("glitch_busy_seen", {31'h0, saw_busy}, 32'h1);
        checkOutput("glitch_busy_cleared", {31'h0, BUSY}, 32'h0);
        idleBits(2);

        $display("[TB] reset mid-operation");
        applyStimulus(8'h34, 1'b1);
        driveBit(1'b0);
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        pend = 1'b0;
        checkOutput("midreset_busy", {31'h0, BUSY}, 32'h0);
        idleBits(10);
        applyStimulus(8'h78, 1'b1);
        applyStimulus(8'h56, 1'b1);
        idleBits(2);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            bit         ok;
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            applyStimulus(b, ok);
            idleBits($urandom_range(0, 1));
        end
        if (pend) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'b1);
        end
        idleBits(2);

        for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
            @(negedge CLK);
        end
        checkOutput("scoreboard_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Serial receive side of the Hack board's host link: deserialises 8N1 UART frames from the host and assembles consecutive byte pairs (low byte first) into 16-bit Hack words. It feeds the ROM/RAM loader and the keyboard-input path with one-cycle word strobes. Fully synchronous to the system clock; the asynchronous RX pin is synchronised internally.

## Interface
Parameters:
- CLKS_PER_BIT, 434: system clocks per UART bit (50 MHz / 115200); must be ≥ 4.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- RX  input  1  asynchronous serial line, idle high.
- DATA  output  16  last assembled word; {high byte, low byte}; held until the next word completes.
- VALID  output  1  one-cycle pulse when DATA updates.
- ERROR  output  1  one-cycle pulse on framing error (stop bit sampled low).
- BUSY  output  1  high while a frame is in progress or a low byte is pending.

## Operation
- RX passes through a 2-flop synchroniser; both flops reset to 1. The FSM uses only the synchronised value.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE: on synchronised RX = 0, clear the bit timer and go to START.
  - START: at CLKS_PER_BIT/2 (integer divide), sample RX. If 0, clear the timer and go to DATA with bit index 0. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: every CLKS_PER_BIT clocks, sample RX into shift register bit [index], LSB first. After index 7, go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample RX. A 1 completes the byte. A 0 is a framing error: pulse ERROR, discard the byte and any pending low byte, and clear the byte phase to LOW. Either way, return to IDLE.
- Word assembly uses a byte phase flag, LOW or HIGH.
  - A completed byte in LOW phase is stored in the low register and the phase goes to HIGH.
  - A completed byte in HIGH phase loads DATA = {byte, low}, pulses VALID, and the phase goes to LOW.
- No inter-byte timeout. A pending low byte waits indefinitely; only RST or a framing error clears it.
- BUSY = (state ≠ IDLE) OR (phase = HIGH).
- RST at any cycle, including mid-frame: the FSM goes to IDLE, phase to LOW, and all outputs to reset values on the next edge. The remainder of an interrupted frame is received as line activity. Its next falling edge may start a spurious frame; the host is required to idle ≥ 1 frame time after reset.

## Timing
- Reset values: DATA = 16'h0000, VALID = 0, ERROR = 0, BUSY = 0.
- Synchroniser latency: 2 clocks from the RX pin to the FSM.
- The mid-bit sample point is CLKS_PER_BIT/2 after the detected start edge, then every CLKS_PER_BIT.
- VALID and ERROR assert on the clock edge after the stop-bit sample. They are high for exactly one cycle, and both never assert in the same cycle.
- DATA changes only in the cycle VALID is high.
- Minimum spacing between VALID pulses: 20 × CLKS_PER_BIT clocks (two frames).
- Back-to-back frames: a start bit immediately after a stop bit is accepted. The FSM is in IDLE by the middle of the stop bit, so no stop-bit extension is required.

## Structure
- Shared package uart_pkg:
  - the FSM state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - the default CLKS_PER_BIT constant, so the transmit side uses the identical value.
- One sub-module, uart_rx_byte: synchroniser, bit timer, FSM and shift register, with outputs byte[7:0], byte_done and frame_err.
- The top level uart_word_rx holds only the byte phase, the low-byte register, and the DATA/VALID/ERROR/BUSY registers.
- Bit timer width: $clog2(CLKS_PER_BIT).

## Test plan
All scenarios run with CLKS_PER_BIT = 8.
- Reset: hold RST 3 cycles with RX = 1 → DATA = 0000, VALID/ERROR/BUSY = 0.
- Word receive: send bytes 0x34 then 0x12 → exactly one VALID pulse, DATA = 16'h1234, 2 + 8/2 + 1 clocks after the second byte's stop-bit start edge (within ±1 clock).
- Back-to-back words: send 0xEF, 0xBE, 0xAD, 0xDE with no idle gaps → VALID twice, with DATA = BEEF then DEAD; no ERROR.
- Framing error: send 0x55, then 0xAA with stop bit = 0 → one ERROR pulse, no VALID. Then send 0x01, 0x00 → DATA = 16'h0001 (the pending low byte was discarded).
- Start glitch: drive RX low for 2 clocks, then high → no VALID, no ERROR, BUSY returns to 0 within 8 clocks.
- Reset mid-operation: send 0x34, assert RST for 1 cycle during the second byte's data bits, idle 10 bit-times, then send 0x78, 0x56 → DATA = 16'h5678.
